// File: rtl/branch_predictor_bht.sv
// Tagged branch history table with target buffer: combinational lookup from the IF-stage PC,
// trained by ID-stage branch resolution, with single-cycle flush and saturating statistics.
module branch_predictor_bht #(
   parameter int NENTRY   = 16,
   parameter int CTR_BITS = 2,
   parameter int TAG_BITS = 8,
   parameter int ADDR_W   = 32,
   parameter int STAT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              predict_hit,
   output logic              predict_taken,
   output logic [ADDR_W-1:0] predict_target,
   input  logic              update_valid,
   input  logic [ADDR_W-1:0] update_pc,
   input  logic              update_taken,
   input  logic [ADDR_W-1:0] update_target,
   input  logic              update_mispredict,
   input  logic              flush,
   output logic [STAT_W-1:0] stat_updates,
   output logic [STAT_W-1:0] stat_mispredicts
);

   localparam int IDX_W = $clog2(NENTRY);
   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
   localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

   logic [NENTRY-1:0]   valid_q;
   logic [TAG_BITS-1:0] tag_q [NENTRY];
   logic [ADDR_W-1:0]   tgt_q [NENTRY];
   logic [CTR_BITS-1:0] ctr_q [NENTRY];

   logic [IDX_W-1:0]    lk_idx, up_idx;
   logic [TAG_BITS-1:0] lk_tag, up_tag;
   logic                up_hit, up_accept, up_alloc;
   logic                unused_pc_bits;

   function automatic logic [CTR_BITS-1:0] ctr_sat_inc(input logic [CTR_BITS-1:0] v);
      return (v == CTR_MAX) ? v : v + CTR_BITS'(1);
   endfunction

   function automatic logic [CTR_BITS-1:0] ctr_sat_dec(input logic [CTR_BITS-1:0] v);
      return (v == '0) ? v : v - CTR_BITS'(1);
   endfunction

   function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

   // Word-aligned PCs: bits [1:0] and bits above the tag do not take part in indexing.
   assign unused_pc_bits = ^{lookup_pc, update_pc};

   assign lk_idx = lookup_pc[IDX_W+1:2];
   assign lk_tag = lookup_pc[IDX_W+TAG_BITS+1:IDX_W+2];
   assign up_idx = update_pc[IDX_W+1:2];
   assign up_tag = update_pc[IDX_W+TAG_BITS+1:IDX_W+2];

   assign predict_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign predict_taken  = predict_hit && ctr_q[lk_idx][CTR_BITS-1];
   assign predict_target = predict_hit ? tgt_q[lk_idx] : '0;

   assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign up_accept = update_valid && !flush && !rst;
   assign up_alloc  = up_accept && !up_hit && update_taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q          <= '0;
         stat_updates     <= '0;
         stat_mispredicts <= '0;
         for (int i = 0; i < NENTRY; i++) ctr_q[i] <= CTR_WNT;
      end else if (flush) begin
         valid_q <= '0;
      end else if (update_valid) begin
         stat_updates <= stat_sat_inc(stat_updates);
         if (update_mispredict) stat_mispredicts <= stat_sat_inc(stat_mispredicts);
         if (up_hit) begin
            ctr_q[up_idx] <= update_taken ? ctr_sat_inc(ctr_q[up_idx]) : ctr_sat_dec(ctr_q[up_idx]);
         end else if (update_taken) begin
            valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx]   <= CTR_WT;
         end
      end
   end

   // Tag and target storage carries no reset; the valid bit qualifies it.
   always_ff @(posedge clk) begin
      if (up_accept && update_taken) tgt_q[up_idx] <= update_target;
      if (up_alloc) tag_q[up_idx] <= up_tag;
   end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: lookup/update/alias/flush/reset and stat saturation.
module tb_branch_predictor_bht;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lookup_pc;
   logic        predict_hit, predict_taken;
   logic [31:0] predict_target;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic        update_mispredict;
   logic        flush;
   logic [31:0] stat_updates, stat_mispredicts;

   logic        s_hit, s_taken;
   logic [31:0] s_target;
   logic [1:0]  s_updates, s_mispredicts;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_predictor_bht u_dut (
      .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
      .predict_hit(predict_hit), .predict_taken(predict_taken), .predict_target(predict_target),
      .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
      .update_target(update_target), .update_mispredict(update_mispredict), .flush(flush),
      .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
   );

   // Narrow statistics so saturation is reachable in a few updates.
   branch_predictor_bht #(.STAT_W(2)) u_sat (
      .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
      .predict_hit(s_hit), .predict_taken(s_taken), .predict_target(s_target),
      .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
      .update_target(update_target), .update_mispredict(update_mispredict), .flush(flush),
      .stat_updates(s_updates), .stat_mispredicts(s_mispredicts)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      update_valid      = 1'b0;
      update_mispredict = 1'b0;
      flush             = 1'b0;
      rst               = 1'b0;
      #1;
   endtask

   task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic misp);
      update_valid      = 1'b1;
      update_pc         = pc;
      update_taken      = tk;
      update_target     = tgt;
      update_mispredict = misp;
      tick();
   endtask

   task automatic look(input logic [31:0] pc, input logic hit, input logic tk,
                       input logic [31:0] tgt, input string tag);
      lookup_pc = pc;
      #1;
      check_eq({tag, "_hit"}, 32'(predict_hit), 32'(hit));
      check_eq({tag, "_taken"}, 32'(predict_taken), 32'(tk));
      check_eq({tag, "_target"}, predict_target, tgt);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; update_valid = 1'b0; update_mispredict = 1'b0;
      update_pc = '0; update_taken = 1'b0; update_target = '0; lookup_pc = 32'h40;
      @(posedge clk);
      tick();

      look(32'h40, 0, 0, 32'h0, "reset");
      check_eq("reset_upd", stat_updates, 0);
      check_eq("reset_misp", stat_mispredicts, 0);

      // Allocate 0x40 -> 0x80; same-cycle lookup must still miss.
      update_valid = 1'b1; update_pc = 32'h40; update_taken = 1'b1;
      update_target = 32'h80; update_mispredict = 1'b0;
      lookup_pc = 32'h40;
      #1;
      check_eq("bypass_hit", 32'(predict_hit), 0);
      tick();
      look(32'h40, 1, 1, 32'h80, "alloc");
      check_eq("alloc_upd", stat_updates, 1);

      // Counter 2 -> 3 -> 3 -> 3, then 2 (still taken), then 1 (not taken).
      for (int i = 0; i < 3; i++) do_update(32'h40, 1'b1, 32'h80, 1'b0);
      look(32'h40, 1, 1, 32'h80, "sat_hi");
      do_update(32'h40, 1'b0, 32'h0, 1'b1);
      look(32'h40, 1, 1, 32'h80, "nt1");
      do_update(32'h40, 1'b0, 32'h0, 1'b0);
      look(32'h40, 1, 0, 32'h80, "nt2");
      check_eq("ctr_upd", stat_updates, 6);
      check_eq("ctr_misp", stat_mispredicts, 1);

      // 0x440 shares index 0 with 0x40 but has a different tag: replaces it.
      do_update(32'h440, 1'b1, 32'h200, 1'b0);
      look(32'h40, 0, 0, 32'h0, "alias_old");
      look(32'h440, 1, 1, 32'h200, "alias_new");
      do_update(32'h440, 1'b0, 32'h999, 1'b0);
      look(32'h440, 1, 0, 32'h200, "alias_nt");
      do_update(32'h440, 1'b1, 32'h300, 1'b0);
      look(32'h440, 1, 1, 32'h300, "alias_retgt");

      // Not-taken on an empty index: no allocation but counted.
      do_update(32'h84, 1'b0, 32'h123, 1'b1);
      look(32'h84, 0, 0, 32'h0, "nt_empty");
      check_eq("nt_empty_upd", stat_updates, 10);
      check_eq("nt_empty_misp", stat_mispredicts, 2);

      // Mispredict without valid is ignored.
      update_mispredict = 1'b1;
      tick();
      check_eq("misp_novalid", stat_mispredicts, 2);

      // Flush with concurrent update: table emptied, stats frozen.
      flush = 1'b1;
      do_update(32'h40, 1'b1, 32'h80, 1'b1);
      look(32'h440, 0, 0, 32'h0, "flush_440");
      look(32'h40, 0, 0, 32'h0, "flush_40");
      check_eq("flush_upd", stat_updates, 10);
      check_eq("flush_misp", stat_mispredicts, 2);

      // Reset wins over a concurrent update.
      rst = 1'b1;
      do_update(32'h40, 1'b1, 32'h80, 1'b1);
      look(32'h40, 0, 0, 32'h0, "rst_upd");
      check_eq("rst_stat_upd", stat_updates, 0);
      check_eq("rst_stat_misp", stat_mispredicts, 0);
      check_eq("rst_sat_misp", 32'(s_mispredicts), 0);

      // Narrow stats saturate at all-ones and stay there.
      for (int i = 0; i < 4; i++) begin
         do_update(32'h40, 1'b1, 32'h80, 1'b1);
         check_eq("sat_misp", 32'(s_mispredicts), (i < 3) ? i + 1 : 3);
      end
      check_eq("sat_upd", 32'(s_updates), 3);
      check_eq("wide_misp", stat_mispredicts, 4);
      lookup_pc = 32'h40;
      #1;
      check_eq("sat_hit", 32'(s_hit), 1);
      check_eq("sat_taken", 32'(s_taken), 1);
      check_eq("sat_target", s_target, 32'h80);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised branch history table plus branch target buffer (BHT/BTB) for the five-stage MIPS pipeline.
- Looked up combinationally with the IF-stage PC. It supplies a predicted direction and target so fetch can redirect without waiting for the ID-stage comparator.
- Trained by the ID-stage branch resolution: outcome, target, and whether the prediction was wrong.
- Generalises the fixed predict-not-taken / flush-on-pcsrc scheme to N entries of tagged, M-bit saturating counters, with flush and statistics.

Parameters:
- NENTRY, 16, number of table entries; power of two, 2..256; IDX_W = log2(NENTRY).
- CTR_BITS, 2, saturating counter width, 1..4.
- TAG_BITS, 8, PC tag bits stored per entry; IDX_W+TAG_BITS+2 <= ADDR_W.
- ADDR_W, 32, PC / target width.
- STAT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- lookup_pc  in  ADDR_W  IF-stage PC.
- predict_hit  out  1  valid entry with matching tag.
- predict_taken  out  1  hit & counter MSB set.
- predict_target  out  ADDR_W  stored target when hit, else 0.
- update_valid  in  1  resolved branch this cycle (ID stage).
- update_pc  in  ADDR_W  PC of the resolved branch.
- update_taken  in  1  actual outcome.
- update_target  in  ADDR_W  actual branch target (baddr).
- update_mispredict  in  1  prediction was wrong (qualified by update_valid).
- flush  in  1  invalidate all entries.
- stat_updates  out  STAT_W  count of accepted updates.
- stat_mispredicts  out  STAT_W  count of mispredictions.

Behaviour:
- Address fields:
  - index = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_BITS+1:IDX_W+2].
  - pc[1:0] is ignored.
- Each entry holds valid, tag, target and ctr.
- Lookup is purely combinational from the registered table; there is no read latency.
- No write bypass: an update at edge k is visible to lookups only after edge k. A same-cycle lookup to the updated index sees the old contents.
- Update, when update_valid=1 and rst=0 and flush=0:
  - Tag hit:
    - update_taken=1: ctr = min(ctr+1, 2^CTR_BITS-1) and target = update_target.
    - update_taken=0: ctr = max(ctr-1, 0); target is unchanged.
  - Tag miss or invalid entry, update_taken=1: allocate (replace). valid=1, tag, target = update_target, ctr = 2^(CTR_BITS-1) (weakly taken).
  - Tag miss or invalid entry, update_taken=0: no table change.
  - In all three cases, stat_updates increments, and stat_mispredicts increments if update_mispredict=1.
- Statistics counters saturate at all-ones and never wrap.
- Flush:
  - All valid bits clear in one cycle; ctr, tag and target values are don't-care afterwards.
  - Statistics are unaffected.
  - A concurrent update is discarded entirely: no table write, no stat increment.
- Reset:
  - All valid=0, every ctr = 2^(CTR_BITS-1)-1 (weakly not-taken), stat counters = 0.
  - Outputs after reset: predict_hit=0, predict_taken=0, predict_target=0.
  - rst overrides flush and update in the same cycle. Reset mid-stream discards any pending update.
- Aliasing: different PCs with the same index and tag share an entry; this is accepted.
- update_mispredict without update_valid is ignored.
- No internal FSM beyond per-entry counters; the pipeline owns flush/redirect decisions.

Test Plan (NENTRY=16, CTR_BITS=2, TAG_BITS=8):
- Reset, then lookup_pc=0x40 -> predict_hit=0, predict_taken=0, predict_target=0, both stats=0.
- Update pc=0x40 taken, target=0x80 -> next cycle, lookup 0x40 gives hit=1, taken=1 (ctr=2), target=0x80. Same-cycle lookup still shows hit=0.
- Entry at 0x40: taken ×3, then not-taken ×2 -> ctr saturates at 3, then goes to 2 then 1. predict_taken=1 after the first not-taken and 0 after the second.
- Alias: allocate 0x40, then update 0x440 taken target=0x200 (same index, different tag) -> lookup 0x40 gives hit=0; lookup 0x440 gives target=0x200, ctr=2.
- Not-taken update on an empty index (0x84) -> no allocation, lookup hit=0, stat_updates increments.
- flush and update (pc=0x40, mispredict=1) in the same cycle -> all lookups miss next cycle; stat_updates and stat_mispredicts unchanged.
- rst and update asserted together -> table stays empty, stats=0.
- Force stat_mispredicts to all-ones, then apply a mispredict update -> value stays all-ones.
